// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI request arbiter.
// Includes the FSM state encoding and an index-width helper.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    XFER,
    DONE,
    ERR
  } arb_state_t;

  localparam int SPI_DW          = 12;
  localparam int SPI_SYNC_STAGES = 2;

  // Width of an index into n items; never returns 0 so n=1 still gets a bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Requester/SPI-master bundle for spi_req_arbiter.
// master = arbiter side, slave = requesters plus the SPI master.
interface spi_req_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = SPI_DW
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic               busy;
  logic               spi_newd;
  logic [DW-1:0]      spi_din;
  logic               spi_cs;

  modport master (
    input  req, req_data, spi_cs,
    output gnt, done, err, busy, spi_newd, spi_din
  );

  modport slave (
    output req, req_data, spi_cs,
    input  gnt, done, err, busy, spi_newd, spi_din
  );

endinterface

// File: rtl/spi_req_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts one past i_ptr and
// wraps modulo NREQ; the first requester found wins. i_ptr must be < NREQ.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_win,
  output logic            o_any_req
);

  logic [PW-1:0]   w_idx [NREQ];
  logic [NREQ-1:0] w_rot;

  // w_rot[k] is the requester k+1 positions after the pointer
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [PW:0] w_sum;
    assign w_sum      = {1'b0, i_ptr} + (PW+1)'(gi + 1);
    assign w_idx[gi]  = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ))
                                                 : PW'(w_sum);
    assign w_rot[gi]  = i_req[w_idx[gi]];
  end

  always_comb begin
    o_win     = '0;
    o_any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_win     = w_idx[k];
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin sharing of one SPI master among NREQ requesters, with a
// transfer sequencer (newd/cs handshake) and a per-phase watchdog.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DW          = SPI_DW,
  parameter int TIMEOUT     = 1023,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  spi_req_arbiter_if.master bus
);

  localparam int PW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t             r_state;
  arb_state_t             w_state_next;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [CW-1:0]          r_cnt;
  logic [PW-1:0]          r_ptr;
  logic [PW-1:0]          r_gidx;
  logic [DW-1:0]          r_din;

  logic                   w_cs_s;
  logic                   w_cnt_max;
  logic [PW-1:0]          w_win;
  logic                   w_any_req;
  logic                   w_gnt_on;
  logic                   w_done_on;
  logic                   w_err_on;
  logic [NREQ-1:0]        w_sel;

  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_cnt_max = (r_cnt == CW'(TIMEOUT));

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_any_req (w_any_req)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; cs falling beats the watchdog when both happen together
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_any_req) w_state_next = ISSUE;
      ISSUE: begin
        if (!w_cs_s)        w_state_next = XFER;
        else if (w_cnt_max) w_state_next = ERR;
      end
      XFER: begin
        if (w_cs_s)         w_state_next = DONE;
        else if (w_cnt_max) w_state_next = ERR;
      end
      DONE:    w_state_next = IDLE;
      ERR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: everything user-visible decodes straight from registers
  always_comb begin
    w_gnt_on     = (r_state == ISSUE) || (r_state == XFER);
    w_done_on    = (r_state == DONE);
    w_err_on     = (r_state == ERR);
    bus.busy     = (r_state != IDLE);
    bus.spi_newd = (r_state == ISSUE);
    bus.spi_din  = w_gnt_on ? r_din : '0;
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_out
    assign w_sel[gi]    = (r_gidx == PW'(gi));
    assign bus.gnt[gi]  = w_sel[gi] & w_gnt_on;
    assign bus.done[gi] = w_sel[gi] & w_done_on;
    assign bus.err[gi]  = w_sel[gi] & w_err_on;
  end

  // cs comes from the sclk-edge domain; idles high so reset to all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_sync <= '1;
    end else begin
      r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
    end
  end

  // Watchdog counter: cleared on every phase entry, saturates at TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ISSUE: begin
          if (w_state_next == XFER) r_cnt <= '0;
          else if (!w_cnt_max)      r_cnt <= r_cnt + 1'b1;
        end
        XFER:    if (!w_cnt_max) r_cnt <= r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Winner and its word are captured at grant; later req_data changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gidx <= '0;
      r_din  <= '0;
    end else if ((r_state == IDLE) && w_any_req) begin
      r_gidx <= w_win;
      r_din  <= bus.req_data[int'(w_win)*DW +: DW];
    end
  end

  // Pointer moves only on completion so an aborted grant still rotates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= PW'(NREQ - 1);
    end else if ((r_state == DONE) || (r_state == ERR)) begin
      r_ptr <= r_gidx;
    end
  end

endmodule
